pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the pipelined CPU fetch stage. It holds the PC register and computes the next PC for sequential, branch, jump, register-jump and PC-relative-register (bgeal) flows. It adds stall, exception redirect with EPC capture, eret, misaligned-target trapping and an optional return-address stack. The block drives instruction-memory addressing and tells the pipeline when fetch was redirected, so the pipeline can flush.

## Interface
- WIDTH, 32, PC/data width; must be ≥ 32.
- RESET_PC, 32'h0000_3000, PC value after reset.
- EXC_VECTOR, 32'h0000_4180, exception handler entry.
- RAS_DEPTH, 4, return-address-stack entries (power of two, ≥ 2); used only with PC_RAS_EN.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active low
- stall  in  1  hold PC (ignored when exc_req or eret is high)
- npc_sel  in  3  next-PC mode (see Operation)
- branch_taken  in  1  branch condition result for npc_sel=001
- instr  in  32  current instruction; imm16=[15:0], index26=[25:0]
- rs_data  in  WIDTH  register target (jr/jalr/return)
- rd_data  in  WIDTH  byte offset for bgeal
- exc_req  in  1  external exception request
- eret  in  1  return from exception
- pc  out  WIDTH  current PC (registered)
- pc_plus4  out  WIDTH  pc + 4 (combinational)
- epc  out  WIDTH  saved exception PC (registered)
- redirect  out  1  registered; high for one cycle after any non-sequential PC load
- addr_err  out  1  registered; high for one cycle after a misaligned-target trap
- ras_miss  out  1  registered; RAS prediction unusable (return mode only)

## Operation
- Per-edge priority: rst_n=0, then exc_req, then eret, then stall, then npc_sel.
- Reset: pc=RESET_PC, epc=0, redirect=0, addr_err=0, ras_miss=0, RAS count=0, RAS pointer=0.
- exc_req: pc←EXC_VECTOR, epc←pc, redirect←1. It overrides stall.
- eret: pc←epc, redirect←1.
- stall: pc, epc and RAS hold; all pulse outputs ←0.
- npc_sel modes (arithmetic modulo 2^WIDTH):
  - 000: pc_plus4.
  - 001: if branch_taken, pc_plus4 + (sext(imm16)<<2); otherwise pc_plus4.
  - 010: {pc_plus4[WIDTH-1:28], index26, 2'b00}.
  - 011: rs_data.
  - 100: pc_plus4 + rd_data.
  - 101 (call): target as 010; pushes pc_plus4.
  - 110 (return): target as 011; pops.
  - 111: treated as 000.
- redirect←1 when the loaded value differs from pc_plus4 because of mode choice. This covers a taken 001, 010–110, exc and eret. A not-taken 001, 000 and 111 give 0.
- Misaligned target: when mode 011, 100, 110 or eret produces a target with [1:0]≠0:
  - pc←EXC_VECTOR, epc←pc, addr_err←1, redirect←1.
  - No RAS pop occurs.
- exc_req and eret both high: exc_req wins; epc←pc.

## Timing
- Single cycle: the next PC is computed combinationally from the inputs and pc, then loaded on the rising clk edge.
- pc_plus4 follows pc with no latency.
- Pulse outputs are registered one cycle after the causing edge and last exactly one cycle unless re-triggered.
- No multi-cycle state; RAS updates on the same edge as pc.

## Configuration
- PC_RAS_EN defined:
  - RAS_DEPTH-entry circular stack plus a saturating count (0..RAS_DEPTH).
  - Push (mode 101) writes at the pointer, then increments it. When full, it overwrites the oldest entry and count stays RAS_DEPTH.
  - Pop (mode 110) with count>0 and top==rs_data: target=top, ras_miss←0.
  - Pop with count=0 or top≠rs_data: target=rs_data, ras_miss←1.
  - Count and pointer decrement on every pop when count>0.
- PC_RAS_EN undefined:
  - No stack storage.
  - 101 behaves exactly as 010 and 110 exactly as 011.
  - ras_miss is tied to 0.

## Test plan
- Reset then 3 cycles of npc_sel=000, stall=0 → pc = 0x3000, 0x3004, 0x3008, 0x300C; redirect=0 throughout.
- pc=0x3010, npc_sel=001, imm16=0xFFFC, branch_taken=1 → pc=0x3004, redirect=1 the next cycle; repeat with branch_taken=0 → pc=0x3014, redirect=0.
- pc=0x3020, stall=1 and exc_req=1 together → pc=0x4180, epc=0x3020; then eret=1 → pc=0x3020, redirect=1.
- npc_sel=011, rs_data=0x3042 → pc=0x4180, epc=old pc, addr_err=1 for one cycle.
- PC_RAS_EN, RAS_DEPTH=4:
  - 5 calls, each from a distinct pc.
  - 4 returns with matching rs_data → ras_miss=0 on each.
  - 5th return → ras_miss=1 and pc=rs_data, because the first entry was overwritten.
- PC_RAS_EN undefined: call with index26=0x0000C10 from pc 0x3000 → pc=0x0000_3040; return with rs_data=0x3004 → pc=0x3004, ras_miss=0.

Source files
------------

// File: rtl/pc_unit_if.sv
// pc_unit_if: control, target and status bundle between the fetch pipeline and pc_unit
interface pc_unit_if #(parameter int WIDTH = 32);
   logic stall;
   logic [2:0] npc_sel;
   logic branch_taken;
   logic [31:0] instr;
   logic [WIDTH-1:0] rs_data;
   logic [WIDTH-1:0] rd_data;
   logic exc_req;
   logic eret;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] pc_plus4;
   logic [WIDTH-1:0] epc;
   logic redirect;
   logic addr_err;
   logic ras_miss;
   modport master (
      output stall, npc_sel, branch_taken, instr, rs_data, rd_data, exc_req, eret,
      input pc, pc_plus4, epc, redirect, addr_err, ras_miss
   );
   modport slave (
      input stall, npc_sel, branch_taken, instr, rs_data, rd_data, exc_req, eret,
      output pc, pc_plus4, epc, redirect, addr_err, ras_miss
   );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with exception redirect and optional return-address stack (PC_RAS_EN)
module pc_unit #(
   parameter int WIDTH = 32,
   parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_3000,
   parameter logic [WIDTH-1:0] EXC_VECTOR = 32'h0000_4180,
   parameter int RAS_DEPTH = 4
) (
   input logic clk,
   input logic rst_n,
   pc_unit_if.slave bus
);
   logic [WIDTH-1:0] pc_q, epc_q, p4, tgt, boff, jt;
   logic jmp, chk, push, pop, pop_miss, bad, adv, red_q, aerr_q, miss_q, unused;
   if (WIDTH < 32 || RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_cfg
      $error("pc_unit: WIDTH must be >= 32 and RAS_DEPTH a power of two >= 2");
   end
   assign p4 = pc_q + WIDTH'(4);
   assign boff = {{(WIDTH-18){bus.instr[15]}}, bus.instr[15:0], 2'b00};
   assign jt = {p4[WIDTH-1:28], bus.instr[25:0], 2'b00};
   always_comb begin
      tgt = p4;
      jmp = 1'b0;
      chk = 1'b0;
      push = 1'b0;
      pop = 1'b0;
      case (bus.npc_sel)
         3'b001: begin
            tgt = bus.branch_taken ? p4 + boff : p4;
            jmp = bus.branch_taken;
         end
         3'b010: begin
            tgt = jt;
            jmp = 1'b1;
         end
         3'b011: begin
            tgt = bus.rs_data;
            jmp = 1'b1;
            chk = 1'b1;
         end
         3'b100: begin
            tgt = p4 + bus.rd_data;
            jmp = 1'b1;
            chk = 1'b1;
         end
         3'b101: begin
            tgt = jt;
            jmp = 1'b1;
            push = 1'b1;
         end
         3'b110: begin
            // a RAS hit means top equals rs_data, so rs_data is the target either way
            tgt = bus.rs_data;
            jmp = 1'b1;
            chk = 1'b1;
            pop = 1'b1;
         end
         default: ;
      endcase
   end
   // eret outranks stall, so its misalignment trap fires even while stalled
   assign bad = bus.eret ? |epc_q[1:0] : ~bus.stall & chk & |tgt[1:0];
   assign adv = ~bus.exc_req & ~bus.eret & ~bus.stall & ~bad;
   always_ff @(posedge clk)
      if (!rst_n) begin
         pc_q <= RESET_PC;
         epc_q <= '0;
         red_q <= 1'b0;
         aerr_q <= 1'b0;
         miss_q <= 1'b0;
      end else if (bus.exc_req || bad) begin
         pc_q <= EXC_VECTOR;
         epc_q <= pc_q;
         red_q <= 1'b1;
         aerr_q <= ~bus.exc_req;
         miss_q <= 1'b0;
      end else if (bus.eret) begin
         pc_q <= epc_q;
         red_q <= 1'b1;
         aerr_q <= 1'b0;
         miss_q <= 1'b0;
      end else if (bus.stall) begin
         red_q <= 1'b0;
         aerr_q <= 1'b0;
         miss_q <= 1'b0;
      end else begin
         pc_q <= tgt;
         red_q <= jmp;
         aerr_q <= 1'b0;
         miss_q <= pop & pop_miss;
      end
`ifdef PC_RAS_EN
   localparam int PW = $clog2(RAS_DEPTH);
   logic [WIDTH-1:0] stk [RAS_DEPTH];
   logic [PW-1:0] ptr, top_idx;
   logic [PW:0] cnt;
   assign top_idx = ptr - 1'b1;
   assign pop_miss = cnt == '0 || stk[top_idx] != bus.rs_data;
   assign unused = ^bus.instr[31:26];
   always_ff @(posedge clk)
      if (adv && push) stk[ptr] <= p4;
   // pointer wraps naturally; a push when full overwrites the oldest entry
   always_ff @(posedge clk)
      if (!rst_n) begin
         ptr <= '0;
         cnt <= '0;
      end else if (adv && push) begin
         ptr <= ptr + 1'b1;
         cnt <= cnt == (PW+1)'(RAS_DEPTH) ? cnt : cnt + 1'b1;
      end else if (adv && pop && cnt != '0) begin
         ptr <= ptr - 1'b1;
         cnt <= cnt - 1'b1;
      end
`else
   assign pop_miss = 1'b0;
   assign unused = ^{bus.instr[31:26], push, adv};
`endif
   assign bus.pc = pc_q;
   assign bus.pc_plus4 = p4;
   assign bus.epc = epc_q;
   assign bus.redirect = red_q;
   assign bus.addr_err = aerr_q;
   assign bus.ras_miss = miss_q;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed and randomized checks of pc_unit against a queue-based reference model
module tb_pc_unit;
   localparam logic [31:0] RST_PC = 32'h0000_3000;
   localparam logic [31:0] EXC = 32'h0000_4180;
   localparam int DEPTH = 4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   pc_unit_if #(.WIDTH(32)) bus();
   pc_unit #(.WIDTH(32), .RESET_PC(RST_PC), .EXC_VECTOR(EXC), .RAS_DEPTH(DEPTH)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );
   int checks = 0;
   int failures = 0;
   logic [31:0] m_pc, m_epc;
   logic m_red, m_aerr, m_miss;
   logic [31:0] ras[$];
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask
   task automatic trap(input logic mis);
      m_epc = m_pc;
      m_pc = EXC;
      m_red = 1'b1;
      m_aerr = mis;
      m_miss = 1'b0;
   endtask
   task automatic model_step();
      logic [31:0] p4, t, jt;
      int off, sel;
      logic checked;
      p4 = m_pc + 32'd4;
      sel = int'(bus.npc_sel);
      off = $signed(bus.instr[15:0]);
      off = off * 4;
      jt = (p4 & 32'hF000_0000) | (32'(bus.instr[25:0]) << 2);
      checked = sel == 3 || sel == 4 || sel == 6;
      t = p4;
      if (sel == 1 && bus.branch_taken) t = p4 + 32'(off);
      if (sel == 2 || sel == 5) t = jt;
      if (sel == 3 || sel == 6) t = bus.rs_data;
      if (sel == 4) t = p4 + bus.rd_data;
      if (!rst_n) begin
         m_pc = RST_PC;
         m_epc = 0;
         m_red = 0;
         m_aerr = 0;
         m_miss = 0;
         ras.delete();
      end else if (bus.exc_req) trap(1'b0);
      else if (bus.eret) begin
         if (m_epc % 4 != 0) trap(1'b1);
         else begin
            m_pc = m_epc;
            m_red = 1;
            m_aerr = 0;
            m_miss = 0;
         end
      end else if (bus.stall) begin
         m_red = 0;
         m_aerr = 0;
         m_miss = 0;
      end else if (checked && t % 4 != 0) trap(1'b1);
      else begin
         m_pc = t;
         m_red = (sel >= 2 && sel <= 6) || (sel == 1 && bus.branch_taken);
         m_aerr = 0;
         m_miss = 0;
`ifdef PC_RAS_EN
         if (sel == 5) begin
            ras.push_back(p4);
            if (ras.size() > DEPTH) void'(ras.pop_front());
         end
         if (sel == 6) begin
            m_miss = ras.size() == 0 || ras[$] != bus.rs_data;
            if (ras.size() > 0) void'(ras.pop_back());
         end
`endif
      end
   endtask
   task automatic cyc(input logic [2:0] sel = 3'd0, input logic [31:0] ins = 0, input logic [31:0] rs = 0,
                      input logic tk = 0, input logic st = 0, input logic ex = 0, input logic er = 0,
                      input logic [31:0] rd = 0, input logic r = 1);
      rst_n = r;
      bus.npc_sel = sel;
      bus.instr = ins;
      bus.rs_data = rs;
      bus.rd_data = rd;
      bus.branch_taken = tk;
      bus.stall = st;
      bus.exc_req = ex;
      bus.eret = er;
      model_step();
      @(posedge clk);
      #1;
      check("pc", bus.pc, m_pc);
      check("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
      check("epc", bus.epc, m_epc);
      check("redirect", 32'(bus.redirect), 32'(m_red));
      check("addr_err", 32'(bus.addr_err), 32'(m_aerr));
      check("ras_miss", 32'(bus.ras_miss), 32'(m_miss));
   endtask
   initial begin
      logic [31:0] rs, rd;
      logic [2:0] sel;
      cyc(.r(0));
      cyc(.r(0));
      check("rst_pc", bus.pc, 32'h3000);
      check("rst_epc", bus.epc, 32'h0);
      check("rst_redirect", 32'(bus.redirect), 32'd0);
      for (int i = 1; i <= 3; i++) begin
         cyc();
         check("seq_pc", bus.pc, 32'h3000 + 32'(4 * i));
         check("seq_redirect", 32'(bus.redirect), 32'd0);
      end
      cyc(.sel(3'd3), .rs(32'h3010));
      cyc(.sel(3'd1), .ins(32'hFFFC), .tk(1'b1));
      check("br_taken_pc", bus.pc, 32'h3004);
      check("br_taken_redirect", 32'(bus.redirect), 32'd1);
      cyc(.sel(3'd3), .rs(32'h3010));
      cyc(.sel(3'd1), .ins(32'hFFFC));
      check("br_not_taken_pc", bus.pc, 32'h3014);
      check("br_not_taken_redirect", 32'(bus.redirect), 32'd0);
      cyc(.sel(3'd3), .rs(32'h3020));
      cyc(.st(1'b1), .ex(1'b1));
      check("exc_pc", bus.pc, 32'h4180);
      check("exc_epc", bus.epc, 32'h3020);
      cyc(.er(1'b1));
      check("eret_pc", bus.pc, 32'h3020);
      check("eret_redirect", 32'(bus.redirect), 32'd1);
      cyc(.sel(3'd3), .rs(32'h3042));
      check("mis_pc", bus.pc, 32'h4180);
      check("mis_epc", bus.epc, 32'h3020);
      check("mis_addr_err", 32'(bus.addr_err), 32'd1);
      cyc();
      check("mis_addr_err_clear", 32'(bus.addr_err), 32'd0);
`ifdef PC_RAS_EN
      for (int k = 0; k < 5; k++) begin
         cyc(.sel(3'd3), .rs(32'h5000 + 32'(k * 32'h100)));
         cyc(.sel(3'd5), .ins(32'h0000_1400));
      end
      for (int k = 4; k >= 1; k--) begin
         cyc(.sel(3'd6), .rs(32'h5004 + 32'(k * 32'h100)));
         check("ras_hit_miss", 32'(bus.ras_miss), 32'd0);
         check("ras_hit_pc", bus.pc, 32'h5004 + 32'(k * 32'h100));
      end
      cyc(.sel(3'd6), .rs(32'h5004));
      check("ras_overwritten_miss", 32'(bus.ras_miss), 32'd1);
      check("ras_overwritten_pc", bus.pc, 32'h5004);
`else
      cyc(.sel(3'd3), .rs(32'h3000));
      cyc(.sel(3'd5), .ins(32'h0000_0C10));
      check("call_pc", bus.pc, 32'h3040);
      cyc(.sel(3'd6), .rs(32'h3004));
      check("ret_pc", bus.pc, 32'h3004);
      check("ret_ras_miss", 32'(bus.ras_miss), 32'd0);
`endif
      for (int n = 0; n < 400; n++) begin
         sel = 3'($urandom_range(7, 0));
         rs = $urandom;
         rd = $urandom;
         if ($urandom_range(3, 0) != 0) rs[1:0] = 2'b00;
         if ($urandom_range(3, 0) != 0) rd[1:0] = 2'b00;
         if (sel == 3'd6 && ras.size() > 0 && $urandom_range(1, 0) == 1) rs = ras[$];
         cyc(.sel(sel), .ins($urandom), .rs(rs), .rd(rd), .tk(1'($urandom_range(1, 0))),
             .st($urandom_range(4, 0) == 0), .ex($urandom_range(19, 0) == 0),
             .er($urandom_range(19, 0) == 0), .r($urandom_range(99, 0) != 0));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
